// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan driver
package seg7_pkg;
    localparam int IDX_W = 2;
    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef struct packed {
        logic [15:0] hw;
        logic [3:0]  dp;
        logic        lz;
    } shadow_t;
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: debug word inputs and board display outputs
interface seg7_scan_driver_if;
    logic [31:0] data_in;
    logic        half_sel;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  disp_anode;
    logic [7:0]  disp_seg;
    logic        digit_tick;
    modport master (output data_in, half_sel, dp_in, blank_lz, input disp_anode, disp_seg, digit_tick);
    modport slave (input data_in, half_sel, dp_in, blank_lz, output disp_anode, disp_seg, digit_tick);
endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// seg7_hex_decode: nibble to active-low {g,f,e,d,c,b,a} pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed hex display with frame snapshot and anti-ghost blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV_COUNT    = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic clock,
    input logic reset,
    seg7_scan_driver_if.slave bus
);
    localparam int PW = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] P_LAST = PW'(DIV_COUNT - 1);
    logic [PW-1:0]    r_p;
    logic [IDX_W-1:0] r_idx;
    shadow_t          r_shadow;
    logic [3:0]       r_anode;
    logic [7:0]       r_seg;
    logic             r_tick;
    logic             w_last;
    logic             w_blank;
    logic             w_lz_off;
    logic             w_off;
    logic [3:0]       w_nib;
    logic [6:0]       w_hex;
    logic [15:0]      w_upper;
    assign w_last   = r_p == P_LAST;
    assign w_nib    = r_shadow.hw[{r_idx, 2'b00} +: 4];
    assign w_upper  = r_shadow.hw >> {r_idx, 2'b00};
    assign w_lz_off = r_shadow.lz && (r_idx != '0) && (w_upper == '0);
    assign w_off    = w_blank || w_lz_off;
    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign w_blank = 1'b0;
        end else begin : g_blank
            localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
            assign w_blank = r_p < P_BLANK;
        end
    endgenerate
    seg7_hex_decode u_dec (.i_nib(w_nib), .o_seg(w_hex));
    // prescaler and digit index advance together at the end of each slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_p   <= '0;
            r_idx <= '0;
        end else begin
            r_p   <= w_last ? '0 : r_p + 1'b1;
            r_idx <= r_idx + {1'b0, w_last};
        end
    end
    // capture the next frame's content only on the frame boundary so a frame never tears
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_shadow <= '0;
        else if (w_last && (&r_idx)) r_shadow <= {bus.half_sel ? bus.data_in[31:16] : bus.data_in[15:0], bus.dp_in, bus.blank_lz};
    end
    // registered active-low outputs, one cycle behind the scan state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_anode <= ANODE_OFF;
            r_seg   <= SEG_OFF;
            r_tick  <= 1'b0;
        end else begin
            r_anode <= w_off ? ANODE_OFF : ~(4'b0001 << r_idx);
            r_seg   <= w_off ? SEG_OFF : {~r_shadow.dp[r_idx], w_hex};
            r_tick  <= w_last;
        end
    end
    assign bus.disp_anode = r_anode;
    assign bus.disp_seg   = r_seg;
    assign bus.digit_tick = r_tick;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized and directed checks of the scan driver against a cycle-count model
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst;
    int vecs = 0;
    int errs = 0;
    seg7_scan_driver_if bus ();
    seg7_scan_driver_if bus_f ();
    assign bus_f.data_in  = bus.data_in;
    assign bus_f.half_sel = bus.half_sel;
    assign bus_f.dp_in    = bus.dp_in;
    assign bus_f.blank_lz = bus.blank_lz;
    seg7_scan_driver #(.DIV_COUNT(4), .BLANK_CYCLES(1)) dut (.clock(clk), .reset(rst), .bus(bus));
    seg7_scan_driver #(.DIV_COUNT(2), .BLANK_CYCLES(0)) dut_f (.clock(clk), .reset(rst), .bus(bus_f));
    always #5 clk = ~clk;
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    // expected {anode, seg, tick} produced from scan state number k since reset
    function automatic logic [12:0] model_out(int d, int b, int k, logic [15:0] hw, logic [3:0] dp, logic lz);
        int p = k % d;
        int i = (k / d) % 4;
        logic [3:0] nib = hw[4*i +: 4];
        logic tk = (p == d - 1);
        if (p < b || (lz && i > 0 && (hw >> (4 * i)) == 16'h0)) return {4'hF, 8'hFF, tk};
        return {4'hF ^ (4'b0001 << i), ~dp[i], hex_tab[nib], tk};
    endfunction
    int k, kf;
    logic [15:0] sh_hw, shf_hw;
    logic [3:0] sh_dp, shf_dp;
    logic sh_lz, shf_lz;
    logic [12:0] exp_o, exp_f;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 0; sh_hw <= '0; sh_dp <= '0; sh_lz <= 1'b0; exp_o <= {4'hF, 8'hFF, 1'b0};
        end else begin
            exp_o <= model_out(4, 1, k, sh_hw, sh_dp, sh_lz);
            k <= k + 1;
            if (k % 16 == 15) begin
                sh_hw <= bus.half_sel ? bus.data_in[31:16] : bus.data_in[15:0];
                sh_dp <= bus.dp_in;
                sh_lz <= bus.blank_lz;
            end
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            kf <= 0; shf_hw <= '0; shf_dp <= '0; shf_lz <= 1'b0; exp_f <= {4'hF, 8'hFF, 1'b0};
        end else begin
            exp_f <= model_out(2, 0, kf, shf_hw, shf_dp, shf_lz);
            kf <= kf + 1;
            if (kf % 8 == 7) begin
                shf_hw <= bus.half_sel ? bus.data_in[31:16] : bus.data_in[15:0];
                shf_dp <= bus.dp_in;
                shf_lz <= bus.blank_lz;
            end
        end
    end
    task automatic cyc();
        @(negedge clk);
    endtask
    task automatic drive(input logic [31:0] d, input logic h, input logic [3:0] dp, input logic lz);
        bus.data_in = d; bus.half_sel = h; bus.dp_in = dp; bus.blank_lz = lz;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        drive(32'h1234ABCD, 1'b0, 4'hF, 1'b1);
        repeat (3) cyc();
        rst = 1'b0;
        repeat (40) cyc();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 vecs++;
        if ({bus.disp_anode, bus.disp_seg, bus.digit_tick} !== {4'hF, 8'hFF, 1'b0}) begin
            errs++;
            $display("FAIL reset_async: got %h/%h/%b want F/FF/0", bus.disp_anode, bus.disp_seg, bus.digit_tick);
        end
        @(negedge clk) rst = 1'b0;
        cyc();
        vecs++;
        if ({bus.disp_anode, bus.disp_seg} !== {4'hF, 8'hFF}) begin
            errs++;
            $display("FAIL reset_first_blank: got %h/%h want F/FF", bus.disp_anode, bus.disp_seg);
        end
        cyc();
        vecs++;
        if ({bus.disp_anode, bus.disp_seg} !== {4'hE, 8'hC0}) begin
            errs++;
            $display("FAIL reset_digit0: got %h/%h want E/C0", bus.disp_anode, bus.disp_seg);
        end
        repeat (12) begin
            cyc();
            vecs++;
            if ({bus.disp_anode, bus.disp_seg, bus.digit_tick} !== exp_o) begin
                errs++;
                $display("FAIL reset_frame: got %h/%h/%b want %h/%h/%b", bus.disp_anode, bus.disp_seg, bus.digit_tick, exp_o[12:9], exp_o[8:1], exp_o[0]);
            end
        end
    endtask
    task automatic test_scan(input string nm, input logic [31:0] d, input logic h, input logic [3:0] dp, input logic lz, input logic [31:0] segs);
        drive(d, h, dp, lz);
        cyc();
        for (int n = 0; n < 20 && k % 16 != 0; n++) cyc();
        if (k % 16 != 0) begin
            vecs++; errs++;
            $display("FAIL %s_sync: state %0d want frame start", nm, k % 16);
        end
        for (int j = 0; j < 16; j++) begin
            int i = j / 4;
            int p = j % 4;
            logic [7:0] s = segs[8*i +: 8];
            logic vis = (p != 0) && (s != 8'hFF);
            logic [12:0] want = {vis ? 4'hF ^ (4'b0001 << i) : 4'hF, vis ? s : 8'hFF, p == 3};
            cyc();
            vecs++;
            if ({bus.disp_anode, bus.disp_seg, bus.digit_tick} !== want) begin
                errs++;
                $display("FAIL %s_slot%0d: got %h/%h/%b want %h/%h/%b", nm, j, bus.disp_anode, bus.disp_seg, bus.digit_tick, want[12:9], want[8:1], want[0]);
            end
            vecs++;
            if ({bus.disp_anode, bus.disp_seg, bus.digit_tick} !== exp_o) begin
                errs++;
                $display("FAIL %s_model%0d: got %h/%h/%b want %h/%h/%b", nm, j, bus.disp_anode, bus.disp_seg, bus.digit_tick, exp_o[12:9], exp_o[8:1], exp_o[0]);
            end
        end
    endtask
    task automatic test_hex();
        test_scan("hex_lo", 32'h1234ABCD, 1'b0, 4'b0000, 1'b0, {8'h88, 8'h83, 8'hC6, 8'hA1});
        test_scan("hex_hi_dp", 32'h1234ABCD, 1'b1, 4'b0101, 1'b0, {8'hF9, 8'h24, 8'hB0, 8'h19});
    endtask
    task automatic test_lz();
        test_scan("lz_50", 32'h00000050, 1'b0, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0});
        test_scan("lz_zero", 32'h00000000, 1'b0, 4'b1111, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h40});
    endtask
    task automatic test_tearing();
        int f0;
        drive(32'h00001111, 1'b0, 4'b0000, 1'b0);
        cyc();
        for (int n = 0; n < 20 && k % 16 != 0; n++) cyc();
        for (int n = 0; n < 20 && k % 16 != 5; n++) cyc();
        f0 = k / 16;
        drive(32'h00002222, 1'b0, 4'b0000, 1'b0);
        repeat (30) begin
            int s, f, i, p;
            cyc();
            s = k - 1; f = s / 16; i = (s / 4) % 4; p = s % 4;
            if (p != 0 && ((f == f0 && i >= 2) || f == f0 + 1)) begin
                logic [7:0] want = (f == f0) ? 8'hF9 : 8'hA4;
                vecs++;
                if ({bus.disp_anode, bus.disp_seg} !== {4'hF ^ (4'b0001 << i), want}) begin
                    errs++;
                    $display("FAIL tearing_f%0d_d%0d: got %h/%h want %h/%h", f - f0, i, bus.disp_anode, bus.disp_seg, 4'hF ^ (4'b0001 << i), want);
                end
            end
        end
    endtask
    task automatic test_random();
        logic [31:0] masks [4] = '{32'hFFFFFFFF, 32'h000F00FF, 32'h00F0000F, 32'h00000000};
        repeat (300) begin
            if ($urandom_range(3) == 0)
                drive($urandom & masks[$urandom_range(3)], 1'($urandom), 4'($urandom), 1'($urandom));
            cyc();
            vecs++;
            if ({bus.disp_anode, bus.disp_seg, bus.digit_tick} !== exp_o) begin
                errs++;
                $display("FAIL random_k%0d: got %h/%h/%b want %h/%h/%b", k, bus.disp_anode, bus.disp_seg, bus.digit_tick, exp_o[12:9], exp_o[8:1], exp_o[0]);
            end
            vecs++;
            if ($countones(~bus.disp_anode) > 1) begin
                errs++;
                $display("FAIL random_onehot: got anode %h want at most one low", bus.disp_anode);
            end
        end
    endtask
    task automatic test_fast();
        drive(32'h0000C0DE, 1'b0, 4'b1000, 1'b0);
        repeat (40) begin
            int i;
            logic [3:0] want;
            cyc();
            i = ((kf - 1) / 2) % 4;
            want = 4'hF ^ (4'b0001 << i);
            vecs++;
            if (bus_f.disp_anode !== want) begin
                errs++;
                $display("FAIL fast_anode: got %h want %h", bus_f.disp_anode, want);
            end
            vecs++;
            if ({bus_f.disp_anode, bus_f.disp_seg, bus_f.digit_tick} !== exp_f) begin
                errs++;
                $display("FAIL fast_model: got %h/%h/%b want %h/%h/%b", bus_f.disp_anode, bus_f.disp_seg, bus_f.digit_tick, exp_f[12:9], exp_f[8:1], exp_f[0]);
            end
        end
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_hex();
        test_lz();
        test_tearing();
        test_random();
        test_fast();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
